// File: rtl/dot_pkg.sv
// Shared constants and types for the nibble dot-product operand path.
// Lane geometry, loader FSM states and frame-kind encodings.
package dot_pkg;

  localparam int NIBBLE_W = 4;
  localparam int LANES    = 4;
  localparam int VEC_W    = NIBBLE_W * LANES;
  localparam int CNT_W    = $clog2(LANES);

  localparam logic KIND_INPUT  = 1'b0;
  localparam logic KIND_WEIGHT = 1'b1;

  typedef enum logic {
    NO_WEIGHTS = 1'b0,
    ARMED      = 1'b1
  } ld_state_e;

  localparam logic [CNT_W-1:0] LAST_LANE =
    CNT_W'(LANES - 1);

endpackage

// File: rtl/nibble_shift_assembler.sv
// Shifts nibbles into a vector, counts lanes, latches frame kind
// and pulses frame_done on the edge that completes a frame.
module nibble_shift_assembler
  import dot_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fire,
  input  logic                flush,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_is_weight,
  output logic                last_lane,
  output logic                cur_kind,
  output logic                frame_done,
  output logic [VEC_W-1:0]    vec
);

  logic [CNT_W-1:0] count;
  logic [VEC_W-1:0] shift_q;
  logic             kind_q;

  assign vec        = {in_data, shift_q[VEC_W-1:NIBBLE_W]};
  assign last_lane  = (count == LAST_LANE);
  assign cur_kind   = (count == '0) ? in_is_weight : kind_q;
  assign frame_done = fire & last_lane & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      shift_q <= '0;
      kind_q  <= KIND_INPUT;
    end else if (flush) begin
      count   <= '0;
      shift_q <= '0;
    end else if (fire) begin
      shift_q <= vec;
      kind_q  <= cur_kind;
      if (last_lane) count <= '0;
      else           count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dot_operand_loader.sv
// Assembles nibble frames into weight/input vectors and emits
// input vectors paired with atomically committed weights.
module dot_operand_loader
  import dot_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_is_weight,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VEC_W-1:0]    out_weights,
  output logic [VEC_W-1:0]    out_inputs,
  output logic                err_no_weight
);

  ld_state_e        state;
  logic [VEC_W-1:0] active_weights;
  logic [VEC_W-1:0] vec;
  logic             last_lane;
  logic             cur_kind;
  logic             frame_done;
  logic             fire;
  logic             stall;
  logic             consume;
  logic             w_done;
  logic             i_done;

  // Only the nibble that would overwrite a held pair is stalled.
  assign stall = last_lane
               & (cur_kind == KIND_INPUT)
               & (state == ARMED)
               & out_valid & ~out_ready;

  assign in_ready = rst_n & ~stall;
  assign fire     = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign w_done   = frame_done & (cur_kind == KIND_WEIGHT);
  assign i_done   = frame_done & (cur_kind == KIND_INPUT);

  nibble_shift_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .fire         (fire),
    .flush        (flush),
    .in_data      (in_data),
    .in_is_weight (in_is_weight),
    .last_lane    (last_lane),
    .cur_kind     (cur_kind),
    .frame_done   (frame_done),
    .vec          (vec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= NO_WEIGHTS;
      active_weights <= '0;
      out_valid      <= 1'b0;
      out_weights    <= '0;
      out_inputs     <= '0;
      err_no_weight  <= 1'b0;
    end else begin
      if (w_done) begin
        active_weights <= vec;
        state          <= ARMED;
      end
      if (i_done && state == ARMED) begin
        out_inputs  <= vec;
        out_weights <= active_weights;
        out_valid   <= 1'b1;
      end else begin
        if (i_done) err_no_weight <= 1'b1;
        if (consume) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_operand_loader.sv
// Directed bench for dot_operand_loader with immediate assertions.
// Inputs change on negedge; outputs are sampled away from posedge.
module tb_dot_operand_loader;
  import dot_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_data;
  logic               in_is_weight;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_weights;
  logic [15:0]        out_inputs;
  logic               err_no_weight;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dot_operand_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_is_weight  (in_is_weight),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_weights   (out_weights),
    .out_inputs    (out_inputs),
    .err_no_weight (err_no_weight)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Present one nibble; returns at the negedge after it transfers.
  task automatic push(input logic k, input logic [3:0] d);
    int n = 0;
    in_valid     = 1'b1;
    in_data      = d;
    in_is_weight = k;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic k, input logic [15:0] v);
    push(k, v[3:0]);
    push(k, v[7:4]);
    push(k, v[11:8]);
    push(k, v[15:12]);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_is_weight = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_w", out_weights, 0);
    chk("rst_out_i", out_inputs, 0);
    chk("rst_err", err_no_weight, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // basic pair
    out_ready = 1'b1;
    frame(KIND_WEIGHT, 16'h4321);
    chk("t1_no_pair_w", out_valid, 0);
    frame(KIND_INPUT, 16'h8765);
    chk("t1_valid", out_valid, 1);
    chk("t1_w", out_weights, 16'h4321);
    chk("t1_i", out_inputs, 16'h8765);
    chk("t1_err", err_no_weight, 0);
    @(negedge clk);
    chk("t1_consumed", out_valid, 0);

    // backpressure on completing nibble
    out_ready = 1'b0;
    frame(KIND_INPUT, 16'h8765);
    chk("t3_pend", out_valid, 1);
    push(KIND_INPUT, 4'h9);
    push(KIND_INPUT, 4'hA);
    push(KIND_INPUT, 4'hB);
    in_valid = 1'b1;
    in_data  = 4'hC;
    #1;
    chk("t3_stall", in_ready, 0);
    chk("t3_i_hold", out_inputs, 16'h8765);
    @(negedge clk);
    chk("t3_stall2", in_ready, 0);
    chk("t3_hold_v", out_valid, 1);
    chk("t3_i_hold2", out_inputs, 16'h8765);
    out_ready = 1'b1;
    #1;
    chk("t3_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_v_kept", out_valid, 1);
    chk("t3_i_new", out_inputs, 16'hCBA9);

    // weight commit while pair pending
    frame(KIND_WEIGHT, 16'hDCBA);
    chk("t4_w_hold", out_weights, 16'h4321);
    chk("t4_i_hold", out_inputs, 16'hCBA9);
    chk("t4_v", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_cons", out_valid, 0);
    frame(KIND_INPUT, 16'h4321);
    chk("t4_w_new", out_weights, 16'hDCBA);
    chk("t4_i_new", out_inputs, 16'h4321);
    @(negedge clk);

    // flush
    push(KIND_INPUT, 4'h1);
    push(KIND_INPUT, 4'h2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    frame(KIND_INPUT, 16'hCBA9);
    chk("t5_v", out_valid, 1);
    chk("t5_i", out_inputs, 16'hCBA9);
    @(negedge clk);
    chk("t5_cons", out_valid, 0);
    push(KIND_INPUT, 4'h1);
    push(KIND_INPUT, 4'h2);
    push(KIND_INPUT, 4'h3);
    flush = 1'b1;
    push(KIND_INPUT, 4'h4);
    flush = 1'b0;
    chk("t5_flush_last", out_valid, 0);
    frame(KIND_INPUT, 16'h8765);
    chk("t5_after_v", out_valid, 1);
    chk("t5_after_i", out_inputs, 16'h8765);
    @(negedge clk);

    // reset mid-frame with pair pending
    out_ready = 1'b0;
    frame(KIND_INPUT, 16'h4321);
    chk("t6_pend", out_valid, 1);
    push(KIND_INPUT, 4'h5);
    push(KIND_INPUT, 4'h6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_v", out_valid, 0);
    chk("t6_w", out_weights, 0);
    chk("t6_i", out_inputs, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_rel", in_ready, 1);
    @(negedge clk);

    // input before any weights
    frame(KIND_INPUT, 16'h1111);
    chk("t2_no_v", out_valid, 0);
    chk("t2_err", err_no_weight, 1);
    frame(KIND_WEIGHT, 16'h4321);
    out_ready = 1'b1;
    frame(KIND_INPUT, 16'h8765);
    chk("t2_v", out_valid, 1);
    chk("t2_w", out_weights, 16'h4321);
    chk("t2_i", out_inputs, 16'h8765);
    chk("t2_err_sticky", err_no_weight, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed",
             n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
